// File: rtl/switch_debouncer.sv
// Per-channel switch debouncer: two-flop synchroniser, stability counter,
// registered clean level and single-cycle rise/fall strobes.
module switch_debouncer #(
   parameter int unsigned NUM_SWITCHES   = 2,
   parameter int unsigned DEBOUNCE_LIMIT = 250
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic [NUM_SWITCHES-1:0] i_switch,
   output logic [NUM_SWITCHES-1:0] o_switch,
   output logic [NUM_SWITCHES-1:0] o_rise,
   output logic [NUM_SWITCHES-1:0] o_fall
);

   localparam int unsigned  CW        = $clog2(DEBOUNCE_LIMIT);
   localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

   logic [NUM_SWITCHES-1:0] sync1;
   logic [NUM_SWITCHES-1:0] sync2;
   logic [NUM_SWITCHES-1:0] state;
   logic [NUM_SWITCHES-1:0] rise;
   logic [NUM_SWITCHES-1:0] fall;
   logic [CW-1:0]           count [NUM_SWITCHES];

   logic [NUM_SWITCHES-1:0] state_nxt;
   logic [NUM_SWITCHES-1:0] rise_nxt;
   logic [NUM_SWITCHES-1:0] fall_nxt;
   logic [CW-1:0]           count_nxt [NUM_SWITCHES];

   // Qualification: any return to the accepted level restarts the window.
   always_comb begin
      state_nxt = state;
      rise_nxt  = '0;
      fall_nxt  = '0;
      for (int i = 0; i < int'(NUM_SWITCHES); i++) begin
         count_nxt[i] = '0;
         if (sync2[i] != state[i]) begin
            if (count[i] == COUNT_MAX) begin
               state_nxt[i] = sync2[i];
               rise_nxt[i]  = sync2[i];
               fall_nxt[i]  = ~sync2[i];
            end else begin
               count_nxt[i] = count[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         sync1 <= '0;
         sync2 <= '0;
         state <= '0;
         rise  <= '0;
         fall  <= '0;
         for (int i = 0; i < int'(NUM_SWITCHES); i++) begin
            count[i] <= '0;
         end
      end else begin
         sync1 <= i_switch;
         sync2 <= sync1;
         state <= state_nxt;
         rise  <= rise_nxt;
         fall  <= fall_nxt;
         for (int i = 0; i < int'(NUM_SWITCHES); i++) begin
            count[i] <= count_nxt[i];
         end
      end
   end

   assign o_switch = state;
   assign o_rise   = rise;
   assign o_fall   = fall;

endmodule
